// File: rtl/miner_multicore_ctrl.sv
// rtl/miner_multicore_ctrl.sv - multicore nonce issue, round-loop schedule and golden-nonce FIFO
// Drives NUM_CORES hasher pairs with interleaved nonces and queues zero-hash hits for draining.
module miner_multicore_ctrl #(
  parameter int LOOP_LOG2  = 5,
  parameter int NUM_CORES  = 2,
  parameter int PIPE_SLOTS = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic                     work_valid,
  input  logic [255:0]             midstate_in,
  input  logic [95:0]              data_in,
  input  logic [31:0]              nonce_start,
  output logic [255:0]             state_out,
  output logic [512*NUM_CORES-1:0] data_out,
  output logic [5:0]               cnt,
  output logic                     feedback,
  input  logic [32*NUM_CORES-1:0]  hash2_in,
  output logic                     gn_valid,
  input  logic                     gn_ready,
  output logic [31:0]              gn_nonce,
  output logic [3:0]               gn_core,
  output logic                     gn_overflow,
  output logic                     nonce_wrap
);

  localparam int LOOP   = 1 << LOOP_LOG2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CW     = PTR_W + 1;
  localparam int WARM_W = $clog2(PIPE_SLOTS + 1);
  localparam logic [5:0]   CNT_MASK = 6'(LOOP - 1);
  localparam logic [31:0]  BACK_OFF = 32'(NUM_CORES * PIPE_SLOTS);
  localparam logic [383:0] PAD      = {32'h00000280, 320'h0, 32'h80000000};

  logic [5:0]               cnt_q, cnt_d, cnt_next;
  logic                     feedback_q, feedback_d, feedback_d1_q;
  logic [31:0]              base_q, base_d, base_sum;
  logic                     carry, boundary;
  logic [255:0]             midstate_q, midstate_d, state_q;
  logic [95:0]              datareg_q, datareg_d;
  logic [512*NUM_CORES-1:0] data_out_q, data_out_d;
  logic [WARM_W-1:0]        warm_q, warm_d;
  logic                     warm_done, check_en;
  logic                     wrap_q, wrap_d, ovf_q, ovf_d;
  logic [NUM_CORES-1:0]     hit_vec, hit_q, hit_d, pend_q, pend_d, pick_oh;
  logic [31:0]              hit_base_q, hit_base_d, pend_base_q, pend_base_d;
  logic [3:0]               pick_idx;
  logic                     push_req, push, pop, full, drop_hit, mem_we;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [35:0]              entry;
  logic [35:0]              mem_q [FIFO_DEPTH];

  assign gn_valid = (count_q != '0);

  always_comb begin
    cnt_next  = (cnt_q + 6'd1) & CNT_MASK;
    boundary  = (cnt_next == 6'd0);
    {carry, base_sum} = {1'b0, base_q} + 33'(NUM_CORES);
    warm_done = (warm_q == WARM_W'(PIPE_SLOTS));
    check_en  = !feedback_d1_q && warm_done;
    hit_vec   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      hit_vec[k] = check_en && (hash2_in[32*k +: 32] == 32'd0);
    end
    // Descending scan so the lowest pending core wins.
    pick_oh  = '0;
    pick_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_idx   = 4'(k);
      end
    end
    entry    = {pick_idx, pend_base_q + {28'd0, pick_idx}};
    push_req = |pend_q;
    pop      = gn_valid && gn_ready;
    full     = (count_q == CW'(FIFO_DEPTH));
    push     = push_req && (!full || pop);
    drop_hit = (|hit_q) && (|pend_q);

    cnt_d       = cnt_next;
    feedback_d  = (cnt_next != 6'd0);
    base_d      = boundary ? base_sum : base_q;
    midstate_d  = midstate_q;
    datareg_d   = datareg_q;
    warm_d      = (boundary && !warm_done) ? warm_q + WARM_W'(1) : warm_q;
    wrap_d      = wrap_q | (boundary & carry);
    ovf_d       = ovf_q | drop_hit | (push_req & ~push);
    hit_d       = hit_vec;
    hit_base_d  = base_q - BACK_OFF;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    if (push_req) begin
      pend_d = pend_q & ~pick_oh;
    end else if (|hit_q) begin
      pend_d      = hit_q;
      pend_base_d = hit_base_q;
    end
    mem_we   = push;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    if (work_valid) begin
      cnt_d      = '0;
      feedback_d = 1'b0;
      base_d     = nonce_start;
      midstate_d = midstate_in;
      datareg_d  = data_in;
      warm_d     = '0;
      wrap_d     = 1'b0;
      ovf_d      = 1'b0;
      hit_d      = '0;
      pend_d     = '0;
      mem_we     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end

    for (int k = 0; k < NUM_CORES; k++) begin
      data_out_d[512*k +: 512] = {PAD, base_d + 32'(k), datareg_d};
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      feedback_q    <= 1'b0;
      feedback_d1_q <= 1'b0;
      base_q        <= '0;
      midstate_q    <= '0;
      datareg_q     <= '0;
      state_q       <= '0;
      data_out_q    <= '0;
      warm_q        <= '0;
      wrap_q        <= 1'b0;
      ovf_q         <= 1'b0;
      hit_q         <= '0;
      hit_base_q    <= '0;
      pend_q        <= '0;
      pend_base_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cnt_q         <= cnt_d;
      feedback_q    <= feedback_d;
      feedback_d1_q <= feedback_q;
      base_q        <= base_d;
      midstate_q    <= midstate_d;
      datareg_q     <= datareg_d;
      state_q       <= midstate_d;
      data_out_q    <= data_out_d;
      warm_q        <= warm_d;
      wrap_q        <= wrap_d;
      ovf_q         <= ovf_d;
      hit_q         <= hit_d;
      hit_base_q    <= hit_base_d;
      pend_q        <= pend_d;
      pend_base_q   <= pend_base_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign cnt         = cnt_q;
  assign feedback    = feedback_q;
  assign state_out   = state_q;
  assign data_out    = data_out_q;
  assign gn_nonce    = gn_valid ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign gn_core     = gn_valid ? mem_q[rd_ptr_q][35:32] : 4'd0;
  assign gn_overflow = ovf_q;
  assign nonce_wrap  = wrap_q;

endmodule
